iob_master: RTL and testbench
=============================

Name: iob_master

Overview:
- I/O bus master sequencer. It accepts one transfer at a time from the FSB-side I/O bridge through the IORDREQ/IOWRREQ request pair.
- It runs a 68000-style asynchronous bus cycle on the slow I/O bus: AS/DS strobes, DTACK termination, or a VPA/E-clock synchronous cycle for 6800-type peripherals such as the VIA.
- It reports progress to the bridge via IOACT, IODONE and IOBERR, and controls the bridge FIFO output buffers.
- It sits between the bridge FIFO primary level and the I/O bus pins, in the I/O bus clock domain.

Parameters:
- TOUT_W, 8, width of the bus-timeout counter.
- TOUT_MAX, 200, CLK cycles in S_STRB before forcing a bus error.
- RECOV, 2, idle CLK cycles after strobe negation before the next cycle may start.

Ports:
- CLK  in  1  I/O bus clock.
- nRES  in  1  asynchronous active-low reset.
- IORDREQ  in  1  read request from bridge; level, held until IOACT seen.
- IOWRREQ  in  1  write request from bridge; mutually exclusive with IORDREQ.
- IOL0  in  1  lower byte strobe from FIFO primary level.
- IOU0  in  1  upper byte strobe from FIFO primary level.
- IOACT  out  1  transfer in progress.
- IODONE  out  1  data phase complete (read data latched / write accepted).
- IOBERR  out  1  transfer ended in bus error.
- IOBUS_nAS  out  1  address strobe.
- IOBUS_nLDS  out  1  lower data strobe.
- IOBUS_nUDS  out  1  upper data strobe.
- IOBUS_RnW  out  1  bus direction; 1 = read.
- nAoutOE  out  1  address output enable from FIFO.
- nDoutOE  out  1  write-data output enable.
- nDinLE  out  1  read-data latch enable; rising edge latches.
- nDTACK  in  1  asynchronous transfer acknowledge.
- nVPA  in  1  valid peripheral address.
- nBERR  in  1  external bus error.
- E  in  1  6800 E clock, free-running at CLK/10.

Behaviour:
- Reset values: IOACT=0, IODONE=0, IOBERR=0, all strobes and nDinLE = 1, nAoutOE=1, nDoutOE=1, IOBUS_RnW=1, state S_IDLE, counters 0.
- Reset applied mid-cycle releases all strobes asynchronously.
- nDTACK, nVPA, nBERR and E each pass through a 2-FF synchronizer; all decisions use the synchronized values.
- EFall = synchronized E was 1 last cycle and is 0 now.
- S_IDLE:
  - nAoutOE=1, IOACT=0.
  - Leave on (IORDREQ|IOWRREQ) && recovery counter==0; latch RnW=IORDREQ, L=IOL0, U=IOU0.
  - Go to S_ADDR.
- S_ADDR (1 cycle):
  - IOACT=1, nAoutOE=0, RnW driven; nDoutOE=0 if write.
  - Go to S_AS.
- S_AS (1 cycle):
  - nAS=0.
  - Read: nLDS/nUDS asserted from latched L/U this same cycle.
  - Go to S_STRB.
- S_STRB:
  - Write: data strobes assert on entry (one cycle after AS).
  - Timeout counter increments each cycle.
  - Priority: BERR > DTACK > VPA > timeout.
  - BERR → S_TERM with err=1.
  - DTACK → S_TERM.
  - VPA → S_VMA.
  - counter==TOUT_MAX → S_TERM with err=1.
- S_VMA:
  - Wait for the first EFall, then a second EFall (a full E period).
  - Go to S_TERM.
  - BERR while waiting still wins.
- S_TERM (1 cycle):
  - nDinLE=0 on reads; IODONE pulses 1 cycle; IOBERR=err (held until IDLE).
  - Go to S_NEG.
- S_NEG:
  - Negate all strobes; nDoutOE=1.
  - Wait until synchronized nDTACK=1 and nVPA=1 (no hang-over into the next cycle).
  - Load recovery counter = RECOV; go to S_IDLE.
  - IOACT drops on entry to S_IDLE.
- A transfer with L=U=0 still runs AS-only and terminates normally.
- A request withdrawn before S_IDLE samples it is ignored.
- IODONE always precedes IOACT fall by at least 1 cycle.
- Every started cycle ends with exactly one IODONE pulse.

Optional Feature:
- Macro IOBM_TIMEOUT_EN.
- Defined: the S_STRB timeout counter forces IOBERR as above.
- Undefined: no counter is built; S_STRB waits indefinitely for DTACK/VPA/BERR; TOUT_W and TOUT_MAX are unused.

Decomposition:
- Shared package iob_pkg:
  - state enum (S_IDLE, S_ADDR, S_AS, S_STRB, S_VMA, S_TERM, S_NEG);
  - default TOUT_MAX and RECOV constants;
  - E period constant (10).
- One sub-module: iob_sync2, a 2-FF synchronizer with reset value parameter, instantiated for nDTACK, nVPA, nBERR and E.

Test Plan:
- Write, IOL0=1, IOU0=0, DTACK returned 3 cycles after nLDS falls:
  - nAS falls 2 cycles after request;
  - nUDS stays 1;
  - IODONE one pulse;
  - IOACT low before the next request is accepted;
  - IOBERR=0.
- Read, both strobes, DTACK → nDinLE low exactly 1 cycle, in S_TERM; IOBUS_RnW=1 throughout.
- nVPA asserted, DTACK never → strobes held across 2 E falling edges, then IODONE; cycle length 13–23 CLKs.
- No response (timeout enabled) → IOBERR=1 and IODONE pulse exactly TOUT_MAX cycles into S_STRB; with macro undefined, strobes remain asserted after 1000 cycles.
- nBERR and nDTACK asserted in the same cycle → IOBERR=1.
- nRES pulsed low in S_STRB → strobes high immediately; IOACT=0; new request after reset completes normally.

Source files
------------

// File: rtl/iob_pkg.sv
// Shared types and constants for the I/O bus master sequencer.
//   iob_state_e  : bus-cycle sequencer states
//   IOB_TOUT_MAX : default S_STRB timeout in CLK cycles
//   IOB_RECOV    : default idle recovery cycles after strobe negation
//   IOB_E_PERIOD : 6800 E clock period in CLK cycles
package iob_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_AS   = 3'd2,
    S_STRB = 3'd3,
    S_VMA  = 3'd4,
    S_TERM = 3'd5,
    S_NEG  = 3'd6
  } iob_state_e;

  localparam int IOB_TOUT_MAX = 200;
  localparam int IOB_RECOV    = 2;
  localparam int IOB_E_PERIOD = 10;

endpackage

// File: rtl/iob_sync2.sv
// Two-flop synchronizer for asynchronous I/O bus inputs.
//   CLK   : destination clock
//   nRES  : async active-low reset, flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (2 CLK latency)
module iob_sync2
  import iob_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic nRES,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/iob_master.sv
// I/O bus master sequencer. Takes one read/write request at a time from the
// FSB-side bridge and runs a 68000-style async bus cycle (AS/DS, DTACK) or a
// VPA/E-clock synchronous cycle, reporting IOACT/IODONE/IOBERR back.
//   CLK, nRES             : I/O bus clock, async active-low reset
//   IORDREQ/IOWRREQ       : level requests, held until IOACT seen
//   IOL0/IOU0             : byte strobes from FIFO primary level
//   IOACT/IODONE/IOBERR   : progress / data phase done / bus error
//   IOBUS_nAS/nLDS/nUDS   : bus strobes; IOBUS_RnW direction (1 = read)
//   nAoutOE/nDoutOE       : address / write-data output enables
//   nDinLE                : read-data latch enable (rising edge latches)
//   nDTACK/nVPA/nBERR/E   : async bus inputs, synchronized internally
// Build option: define IOBM_TIMEOUT_EN to build the S_STRB timeout counter;
// without it S_STRB waits indefinitely for DTACK/VPA/BERR.
module iob_master
  import iob_pkg::*;
#(
  parameter int TOUT_W   = 8,
  parameter int TOUT_MAX = IOB_TOUT_MAX,
  parameter int RECOV    = IOB_RECOV
) (
  input  logic CLK,
  input  logic nRES,
  input  logic IORDREQ,
  input  logic IOWRREQ,
  input  logic IOL0,
  input  logic IOU0,
  output logic IOACT,
  output logic IODONE,
  output logic IOBERR,
  output logic IOBUS_nAS,
  output logic IOBUS_nLDS,
  output logic IOBUS_nUDS,
  output logic IOBUS_RnW,
  output logic nAoutOE,
  output logic nDoutOE,
  output logic nDinLE,
  input  logic nDTACK,
  input  logic nVPA,
  input  logic nBERR,
  input  logic E
);

  localparam int REC_W = (RECOV < 2) ? 1 : $clog2(RECOV + 1);

  iob_state_e       state, state_nxt;
  logic             dtack_n_s, vpa_n_s, berr_n_s, e_s, e_prev, efall;
  logic             rnw_q, l_q, u_q, err_q, vma_half;
  logic [REC_W-1:0] rec_cnt;
  logic             req, tout_hit, term_err;

  iob_sync2 #(.RST_VAL(1'b1)) u_sync_dtack (.CLK(CLK), .nRES(nRES), .d(nDTACK), .q(dtack_n_s));
  iob_sync2 #(.RST_VAL(1'b1)) u_sync_vpa   (.CLK(CLK), .nRES(nRES), .d(nVPA),   .q(vpa_n_s));
  iob_sync2 #(.RST_VAL(1'b1)) u_sync_berr  (.CLK(CLK), .nRES(nRES), .d(nBERR),  .q(berr_n_s));
  iob_sync2 #(.RST_VAL(1'b0)) u_sync_e     (.CLK(CLK), .nRES(nRES), .d(E),      .q(e_s));

  assign efall = e_prev & ~e_s;
  assign req   = IORDREQ | IOWRREQ;

`ifdef IOBM_TIMEOUT_EN
  logic [TOUT_W-1:0] tout_cnt;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES)                tout_cnt <= '0;
    else if (state == S_STRB) tout_cnt <= tout_cnt + 1'b1;
    else                      tout_cnt <= '0;
  end

  // Fires on the TOUT_MAX-th cycle spent in S_STRB.
  assign tout_hit = (state == S_STRB) && (tout_cnt == TOUT_W'(TOUT_MAX - 1));
`else
  logic unused_tout_cfg;
  assign unused_tout_cfg = (TOUT_W > 0) ^ (TOUT_MAX > 0);
  assign tout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    term_err  = 1'b0;
    case (state)
      S_IDLE: if (req && rec_cnt == '0) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_AS;
      S_AS:   state_nxt = S_STRB;
      S_STRB: begin
        if (!berr_n_s) begin
          state_nxt = S_TERM;
          term_err  = 1'b1;
        end else if (!dtack_n_s) begin
          state_nxt = S_TERM;
        end else if (!vpa_n_s) begin
          state_nxt = S_VMA;
        end else if (tout_hit) begin
          state_nxt = S_TERM;
          term_err  = 1'b1;
        end
      end
      S_VMA: begin
        // Second E fall after entry closes the 6800 cycle.
        if (!berr_n_s) begin
          state_nxt = S_TERM;
          term_err  = 1'b1;
        end else if (efall && vma_half) begin
          state_nxt = S_TERM;
        end
      end
      S_TERM: state_nxt = S_NEG;
      // Hold off until the slave has released DTACK/VPA so it cannot
      // terminate the next cycle early.
      S_NEG:  if (dtack_n_s && vpa_n_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transfer attributes, error flag, E tracking and recovery counter
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      rnw_q    <= 1'b1;
      l_q      <= 1'b0;
      u_q      <= 1'b0;
      err_q    <= 1'b0;
      vma_half <= 1'b0;
      e_prev   <= 1'b0;
      rec_cnt  <= '0;
    end else begin
      e_prev <= e_s;
      if (term_err)             err_q <= 1'b1;
      else if (state == S_IDLE) err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rec_cnt != '0) begin
            rec_cnt <= rec_cnt - 1'b1;
          end else if (req) begin
            rnw_q <= IORDREQ;
            l_q   <= IOL0;
            u_q   <= IOU0;
          end
        end
        S_VMA: if (efall) vma_half <= 1'b1;
        S_NEG: begin
          vma_half <= 1'b0;
          if (state_nxt == S_IDLE) rec_cnt <= REC_W'(RECOV);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from the state register so an async reset
  // releases every strobe immediately.
  always_comb begin
    IOACT      = 1'b1;
    IODONE     = 1'b0;
    IOBERR     = 1'b0;
    IOBUS_nAS  = 1'b1;
    IOBUS_nLDS = 1'b1;
    IOBUS_nUDS = 1'b1;
    IOBUS_RnW  = rnw_q;
    nAoutOE    = 1'b0;
    nDoutOE    = rnw_q;
    nDinLE     = 1'b1;
    case (state)
      S_IDLE: begin
        IOACT     = 1'b0;
        IOBUS_RnW = 1'b1;
        nAoutOE   = 1'b1;
        nDoutOE   = 1'b1;
      end
      S_ADDR: ;
      S_AS: begin
        // Reads strobe data with AS; writes wait a cycle for data setup.
        IOBUS_nAS  = 1'b0;
        IOBUS_nLDS = ~(rnw_q & l_q);
        IOBUS_nUDS = ~(rnw_q & u_q);
      end
      S_STRB, S_VMA: begin
        IOBUS_nAS  = 1'b0;
        IOBUS_nLDS = ~l_q;
        IOBUS_nUDS = ~u_q;
      end
      S_TERM: begin
        IOBUS_nAS  = 1'b0;
        IOBUS_nLDS = ~l_q;
        IOBUS_nUDS = ~u_q;
        IODONE     = 1'b1;
        IOBERR     = err_q;
        nDinLE     = ~rnw_q;
      end
      S_NEG: begin
        nDoutOE = 1'b1;
        IOBERR  = err_q;
      end
      default: begin
        IOACT     = 1'b0;
        IOBUS_RnW = 1'b1;
        nAoutOE   = 1'b1;
        nDoutOE   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_master.sv
// Directed bench for iob_master: bus slave responder driven from the
// per-cycle tick task, stats collected per transfer, hand-computed checks.
module tb_iob_master;
  import iob_pkg::*;

  localparam int TB_TOUT  = 200;
  localparam int TB_RECOV = 2;

  logic CLK, nRES, IORDREQ, IOWRREQ, IOL0, IOU0;
  logic IOACT, IODONE, IOBERR, IOBUS_nAS, IOBUS_nLDS, IOBUS_nUDS, IOBUS_RnW;
  logic nAoutOE, nDoutOE, nDinLE, nDTACK, nVPA, nBERR, E;

  iob_master #(.TOUT_W(8), .TOUT_MAX(TB_TOUT), .RECOV(TB_RECOV)) dut (
    .CLK(CLK), .nRES(nRES), .IORDREQ(IORDREQ), .IOWRREQ(IOWRREQ),
    .IOL0(IOL0), .IOU0(IOU0), .IOACT(IOACT), .IODONE(IODONE), .IOBERR(IOBERR),
    .IOBUS_nAS(IOBUS_nAS), .IOBUS_nLDS(IOBUS_nLDS), .IOBUS_nUDS(IOBUS_nUDS),
    .IOBUS_RnW(IOBUS_RnW), .nAoutOE(nAoutOE), .nDoutOE(nDoutOE), .nDinLE(nDinLE),
    .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR), .E(E)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // E free-running at CLK/10, edges offset from CLK edges
  initial begin
    E = 1'b0;
    #3;
    forever #(IOB_E_PERIOD * 5) E = ~E;
  end

  int n_chk, n_err;
  int t, act_n, done_n, dinle_n, dinle_bad, as_n, as_t, done_t, done_late;
  bit uds_lo, lds_lo, rnw_lo, berr_seen, prev_act, prev_done, e_q, efall_tb;
  int resp, resp_dly;  // 0 none, 1 DTACK, 2 VPA, 3 BERR+DTACK

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    t = 0; act_n = 0; done_n = 0; dinle_n = 0; dinle_bad = 0; as_n = 0;
    as_t = -1; done_t = -1; done_late = 0;
    uds_lo = 0; lds_lo = 0; rnw_lo = 0; berr_seen = 0;
    prev_act = 0; prev_done = 0;
  endtask

  // One CLK cycle: sample at negedge, update stats, drive the slave side.
  task automatic tick();
    @(negedge CLK);
    t++;
    if (IOACT) act_n++;
    if (IODONE) begin
      done_n++;
      if (done_t < 0) done_t = t;
      if (IOBERR) berr_seen = 1;
    end
    if (!nDinLE) begin
      dinle_n++;
      if (!IODONE) dinle_bad++;
    end
    if (!IOBUS_nUDS) uds_lo = 1;
    if (!IOBUS_nLDS) lds_lo = 1;
    if (IOACT && !IOBUS_RnW) rnw_lo = 1;
    if (!IOBUS_nAS) begin
      as_n++;
      if (as_t < 0) as_t = t;
    end
    if (prev_act && !IOACT && prev_done) done_late++;
    prev_act = IOACT; prev_done = IODONE;
    efall_tb = e_q & ~E; e_q = E;
    if (IOBUS_nAS) begin
      nDTACK = 1; nVPA = 1; nBERR = 1;
    end else if (as_n >= resp_dly) begin
      case (resp)
        1: nDTACK = 0;
        2: nVPA = 0;
        3: begin nDTACK = 0; nBERR = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic start_xfer(input bit rd, input bit l, input bit u, input int rsp, input int dly);
    clr();
    resp = rsp; resp_dly = dly;
    IOL0 = l; IOU0 = u; IORDREQ = rd; IOWRREQ = !rd;
    for (int i = 0; i < 10 && !IOACT; i++) tick();
    chk("start", IOACT, 1);
    IORDREQ = 0; IOWRREQ = 0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && IOACT; i++) tick();
    chk("idle", IOACT, 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; e_q = 0; efall_tb = 0;
    nRES = 0; IORDREQ = 0; IOWRREQ = 0; IOL0 = 0; IOU0 = 0;
    nDTACK = 1; nVPA = 1; nBERR = 1; resp = 0; resp_dly = 0;
    clr();
    repeat (2) @(negedge CLK);
    chk("rst_ctl", {IOACT, IODONE, IOBERR}, 0);
    chk("rst_strb", {IOBUS_nAS, IOBUS_nLDS, IOBUS_nUDS, IOBUS_RnW}, 4'hF);
    chk("rst_oe", {nAoutOE, nDoutOE, nDinLE}, 3'b111);
    nRES = 1;
    tick();

    // Write, lower byte only, DTACK 3 cycles after nLDS falls
    start_xfer(0, 1, 0, 1, 5);
    chk("wr_lat", t, 1);
    wait_idle(40);
    chk("wr_as_t", as_t, 2);
    chk("wr_lds", lds_lo, 1);
    chk("wr_uds", uds_lo, 0);
    chk("wr_rnw", rnw_lo, 1);
    chk("wr_done", done_n, 1);
    chk("wr_berr", berr_seen, 0);
    chk("wr_order", done_late, 0);

    // Read, both bytes, issued right away: waits out recovery
    start_xfer(1, 1, 1, 1, 3);
    chk("rd_recov", t, TB_RECOV + 1);
    wait_idle(40);
    chk("rd_done", done_n, 1);
    chk("rd_dinle", dinle_n, 1);
    chk("rd_dinle_term", dinle_bad, 0);
    chk("rd_rnw", rnw_lo, 0);
    chk("rd_strb", {lds_lo, uds_lo}, 2'b11);

    // Request pulsed during recovery is never sampled
    clr();
    IORDREQ = 1;
    tick();
    IORDREQ = 0;
    repeat (6) tick();
    chk("withdraw", act_n, 0);

    // VPA cycle: align to an E fall, hold strobes across two E falls
    for (int i = 0; i < 30 && !efall_tb; i++) tick();
    chk("e_align", efall_tb, 1);
    start_xfer(1, 1, 0, 2, 1);
    wait_idle(60);
    chk("vpa_len", int'(as_n >= 13 && as_n <= 23), 1);
    chk("vpa_done", done_n, 1);
    chk("vpa_berr", berr_seen, 0);

    // BERR and DTACK together: bus error wins
    start_xfer(0, 1, 1, 3, 2);
    wait_idle(40);
    chk("berr_err", berr_seen, 1);
    chk("berr_done", done_n, 1);

    // No byte strobes: AS-only cycle still terminates
    start_xfer(1, 0, 0, 1, 2);
    wait_idle(40);
    chk("null_strb", {lds_lo, uds_lo}, 2'b00);
    chk("null_done", done_n, 1);

`ifdef IOBM_TIMEOUT_EN
    // No response: timeout exactly TOUT_MAX cycles into S_STRB
    start_xfer(1, 1, 0, 0, 0);
    wait_idle(TB_TOUT + 40);
    chk("tout_t", done_t, as_t + 1 + TB_TOUT);
    chk("tout_err", berr_seen, 1);
    chk("tout_done", done_n, 1);
`else
    // No response: strobes held indefinitely, DTACK releases it
    start_xfer(1, 1, 0, 0, 0);
    repeat (1000) tick();
    chk("hang_as", IOBUS_nAS, 0);
    chk("hang_lds", IOBUS_nLDS, 0);
    chk("hang_done", done_n, 0);
    resp = 1;
    wait_idle(40);
    chk("hang_rel_done", done_n, 1);
`endif

    // Async reset in S_STRB releases strobes at once
    start_xfer(1, 1, 1, 0, 0);
    for (int i = 0; i < 10 && as_n < 3; i++) tick();
    nRES = 0;
    #1;
    chk("rstmid_strb", {IOBUS_nAS, IOBUS_nLDS, IOBUS_nUDS}, 3'b111);
    chk("rstmid_act", IOACT, 0);
    @(negedge CLK);
    nRES = 1;
    tick();
    start_xfer(0, 0, 1, 1, 2);
    wait_idle(40);
    chk("post_rst_done", done_n, 1);
    chk("post_rst_berr", berr_seen, 0);
    chk("post_rst_uds", uds_lo, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
